// File: rtl/board_input_ctrl_pkg.sv
// Shared state encodings and width helpers for the board input conditioning block.
// Imported by the debounce cell and the top level.
package board_input_ctrl_pkg;

  typedef enum logic [1:0] {
    DB_IDLE_LO   = 2'b00,
    DB_CHK_HI    = 2'b01,
    DB_STABLE_HI = 2'b10,
    DB_CHK_LO    = 2'b11
  } db_state_e;

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/board_input_ctrl_debounce_cell.sv
// One input channel: 2-flop synchroniser, stability counter and debounce FSM.
// level/rise/fall are registered, so nothing combinational reaches the outputs from raw.
module debounce_cell
  import board_input_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic            sync_p0;
  logic            sync_p1;
  db_state_e       state_q;
  db_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic            level_q;
  logic            level_d;
  logic            rise_q;
  logic            rise_d;
  logic            fall_q;
  logic            fall_d;

  // Stage p0/p1: metastability guard on the asynchronous input
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce state, counter and registered output pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DB_IDLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // The entering sample counts as the first stable cycle; exit happens at the terminal count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      DB_IDLE_LO: begin
        if (sync_p1) begin
          state_d = DB_CHK_HI;
          cnt_d   = CNT_ONE;
        end
      end
      DB_CHK_HI: begin
        if (!sync_p1) begin
          state_d = DB_IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_STABLE_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DB_STABLE_HI: begin
        if (!sync_p1) begin
          state_d = DB_CHK_LO;
          cnt_d   = CNT_ONE;
        end
      end
      DB_CHK_LO: begin
        if (sync_p1) begin
          state_d = DB_STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_IDLE_LO;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = DB_IDLE_LO;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/board_input_ctrl.sv
// Input-side board interface: debounces buttons and switches and produces the datapath
// step enable (free-run, single-step and held-button auto-repeat).
module board_input_ctrl
  import board_input_ctrl_pkg::*;
#(
  parameter int NUM_BTN       = 4,
  parameter int NUM_SW        = 7,
  parameter int DEBOUNCE_CYC  = 500000,
  parameter int STEP_BTN      = 0,
  parameter int RUN_SW        = 6,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [NUM_SW-1:0]  sw_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_SW-1:0]  sw_level,
  output logic [NUM_SW-1:0]  sw_change,
  output logic               step_en
);

  localparam int RPT_W = cnt_width(max2(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [RPT_W-1:0] RPT_FIRST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_PERIOD);
  localparam logic [RPT_W-1:0] RPT_ONE    = RPT_W'(1);

  logic [NUM_SW-1:0] sw_rise;
  logic [NUM_SW-1:0] sw_fall;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    debounce_cell #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_cell (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn_raw[g]),
      .level(btn_level[g]),
      .rise (btn_press[g]),
      .fall (btn_release[g])
    );
  end

  for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
    debounce_cell #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_cell (
      .clk  (clk),
      .rst  (rst),
      .raw  (sw_raw[g]),
      .level(sw_level[g]),
      .rise (sw_rise[g]),
      .fall (sw_fall[g])
    );
  end

  assign sw_change = sw_rise | sw_fall;

  logic             run_lvl;
  logic             step_lvl;
  logic             step_press;
  logic             rpt_active_q;
  logic             rpt_active_d;
  logic [RPT_W-1:0] rpt_cnt_q;
  logic [RPT_W-1:0] rpt_cnt_d;
  logic             rpt_pulse_q;
  logic             rpt_pulse_d;

  assign run_lvl    = sw_level[RUN_SW];
  assign step_lvl   = btn_level[STEP_BTN];
  assign step_press = btn_press[STEP_BTN];

  // Repeat counter state: down-counter that fires at 1 and reloads, so it never wraps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpt_active_q <= 1'b0;
      rpt_cnt_q    <= '0;
      rpt_pulse_q  <= 1'b0;
    end else begin
      rpt_active_q <= rpt_active_d;
      rpt_cnt_q    <= rpt_cnt_d;
      rpt_pulse_q  <= rpt_pulse_d;
    end
  end

  always_comb begin
    rpt_active_d = rpt_active_q;
    rpt_cnt_d    = rpt_cnt_q;
    rpt_pulse_d  = 1'b0;
    if (run_lvl || !step_lvl) begin
      rpt_active_d = 1'b0;
      rpt_cnt_d    = '0;
    end else if (step_press) begin
      rpt_active_d = 1'b1;
      rpt_cnt_d    = RPT_FIRST;
    end else if (rpt_active_q) begin
      if (rpt_cnt_q <= RPT_ONE) begin
        rpt_pulse_d = 1'b1;
        rpt_cnt_d   = RPT_RELOAD;
      end else begin
        rpt_cnt_d = rpt_cnt_q - RPT_ONE;
      end
    end
  end

  // Gating with the live level suppresses a repeat landing on the release cycle.
  assign step_en = run_lvl | step_press | (rpt_pulse_q & step_lvl);

endmodule

// File: tb/tb_board_input_ctrl.sv
// Bench for board_input_ctrl: directed tables and sequences plus random stimulus,
// all compared every cycle against a run-length reference model.
module tb_board_input_ctrl;

  localparam int NUM_BTN  = 4;
  localparam int NUM_SW   = 7;
  localparam int DB       = 4;
  localparam int RD       = 20;
  localparam int RP       = 8;
  localparam int STEP_BTN = 0;
  localparam int RUN_SW   = 6;
  localparam int NCH      = NUM_BTN + NUM_SW;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NUM_BTN-1:0] btn_raw = '0;
  logic [NUM_SW-1:0]  sw_raw = '0;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic [NUM_SW-1:0]  sw_level;
  logic [NUM_SW-1:0]  sw_change;
  logic               step_en;

  always #5 clk = ~clk;

  board_input_ctrl #(
    .NUM_BTN(NUM_BTN), .NUM_SW(NUM_SW), .DEBOUNCE_CYC(DB), .STEP_BTN(STEP_BTN),
    .RUN_SW(RUN_SW), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .sw_raw(sw_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .sw_level(sw_level), .sw_change(sw_change), .step_en(step_en)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: each channel flips after DB consecutive synchronised samples disagreeing with it.
  logic [NCH-1:0] m_h1, m_h2, m_lvl, m_rise, m_fall;
  int             m_run [NCH];
  int             cyc = 0;
  int             press_t = 0;
  bit             armed = 1'b0;
  logic           m_step = 1'b0;

  task automatic chk_vec(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%b expected=%b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    m_h1 = '0; m_h2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0;
    for (int i = 0; i < NCH; i++) m_run[i] = 0;
    armed = 1'b0;
    m_step = 1'b0;
  endtask

  task automatic model_edge();
    logic [NCH-1:0] raw_now;
    logic run_l, lvl, pr;
    int n;
    raw_now = {sw_raw, btn_raw};
    cyc++;
    m_rise = '0;
    m_fall = '0;
    if (!rst) begin
      model_clear();
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (m_h2[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_lvl[i] = m_h2[i];
            m_run[i] = 0;
            if (m_h2[i]) m_rise[i] = 1'b1;
            else m_fall[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_h2 = m_h1;
      m_h1 = raw_now;
      run_l = m_lvl[NUM_BTN + RUN_SW];
      lvl   = m_lvl[STEP_BTN];
      pr    = m_rise[STEP_BTN];
      n     = cyc - press_t;
      m_step = run_l | pr | (armed && lvl && n >= RD && ((n - RD) % RP) == 0);
      if (run_l || !lvl) armed = 1'b0;
      else if (pr) begin
        armed = 1'b1;
        press_t = cyc;
      end
    end
  endtask

  task automatic check_outputs();
    chk_vec("btn_level", 16'(btn_level), 16'(m_lvl[NUM_BTN-1:0]));
    chk_vec("btn_press", 16'(btn_press), 16'(m_rise[NUM_BTN-1:0]));
    chk_vec("btn_release", 16'(btn_release), 16'(m_fall[NUM_BTN-1:0]));
    chk_vec("sw_level", 16'(sw_level), 16'(m_lvl[NCH-1:NUM_BTN]));
    chk_vec("sw_change", 16'(sw_change), 16'(m_rise[NCH-1:NUM_BTN] | m_fall[NCH-1:NUM_BTN]));
    chk_bit("step_en", step_en, m_step);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    model_clear();
    #1;
    check_outputs();
    for (int i = 0; i < n; i++) tick();
    rst = 1'b1;
  endtask

  task automatic glitch(input int w, output int presses, output int lvl_hi);
    presses = 0;
    lvl_hi = 0;
    btn_raw[1] = 1'b1;
    for (int i = 0; i < w; i++) begin
      tick();
      if (btn_press[1]) presses++;
      if (btn_level[1]) lvl_hi++;
    end
    btn_raw[1] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (btn_press[1]) presses++;
      if (btn_level[1]) lvl_hi++;
    end
  endtask

  typedef struct {
    logic [NUM_BTN-1:0] btn;
    logic [NUM_SW-1:0]  sw;
    int                 hold;
    logic [NUM_BTN-1:0] exp_btn;
    logic [NUM_SW-1:0]  exp_sw;
  } vec_t;

  initial begin
    vec_t vecs [8];
    int   n, lat, p, lh, cnt;
    int   got_q [$];
    int   exp_q [$];

    model_clear();
    @(negedge clk);

    // 1: inputs ignored under reset, then a switch high at release gives one change pulse
    for (int i = 0; i < 6; i++) begin
      btn_raw = 4'($urandom);
      sw_raw  = 7'($urandom);
      tick();
    end
    btn_raw = '0;
    sw_raw  = 7'b0000010;
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (sw_change[1]) cnt++;
    end
    chk_int("reset_release_sw_change", cnt, 1);
    chk_vec("reset_release_sw_level", 16'(sw_level), 16'h0002);

    // 2: press latency and single-cycle pulse, release latency
    btn_raw[2] = 1'b1;
    lat = 0;
    do begin tick(); lat++; end while (!btn_press[2] && lat < 30);
    chk_int("press_latency", lat, DB + 2);
    chk_bit("press_level", btn_level[2], 1'b1);
    tick();
    chk_bit("press_one_cycle", btn_press[2], 1'b0);
    for (int i = 0; i < 5; i++) tick();
    btn_raw[2] = 1'b0;
    lat = 0;
    do begin tick(); lat++; end while (!btn_release[2] && lat < 30);
    chk_int("release_latency", lat, DB + 2);

    // 3: glitches shorter than the debounce window are ignored
    for (int w = 1; w <= DB; w++) begin
      glitch(w, p, lh);
      chk_int($sformatf("glitch_press_w%0d", w), p, (w >= DB) ? 1 : 0);
      if (w < DB) chk_int($sformatf("glitch_level_w%0d", w), lh, 0);
    end

    // Table of level patterns, including a short glitch and a split hold
    vecs[0] = '{4'b0101, 7'b0010101, 8,  4'b0101, 7'b0010101};
    vecs[1] = '{4'b1010, 7'b1101010, 8,  4'b1010, 7'b1101010};
    vecs[2] = '{4'b0000, 7'b0000000, 3,  4'b1010, 7'b1101010};
    vecs[3] = '{4'b1010, 7'b1101010, 8,  4'b1010, 7'b1101010};
    vecs[4] = '{4'b1111, 7'b1111111, 10, 4'b1111, 7'b1111111};
    vecs[5] = '{4'b0000, 7'b0000000, 10, 4'b0000, 7'b0000000};
    vecs[6] = '{4'b0001, 7'b0000000, 5,  4'b0000, 7'b0000000};
    vecs[7] = '{4'b0001, 7'b0000000, 1,  4'b0001, 7'b0000000};
    for (int v = 0; v < 8; v++) begin
      btn_raw = vecs[v].btn;
      sw_raw  = vecs[v].sw;
      for (int i = 0; i < vecs[v].hold; i++) tick();
      chk_vec($sformatf("table%0d_btn", v), 16'(btn_level), 16'(vecs[v].exp_btn));
      chk_vec($sformatf("table%0d_sw", v), 16'(sw_level), 16'(vecs[v].exp_sw));
    end
    btn_raw = '0;
    for (int i = 0; i < 12; i++) tick();

    // 4: auto-repeat while the step button is held
    btn_raw[STEP_BTN] = 1'b1;
    lat = 0;
    do begin tick(); lat++; end while (!btn_press[STEP_BTN] && lat < 30);
    if (step_en) got_q.push_back(0);
    for (int k = 1; k < 60; k++) begin
      tick();
      if (step_en) got_q.push_back(k);
    end
    exp_q.push_back(0);
    for (int t = RD; t < 60; t += RP) exp_q.push_back(t);
    chk_int("repeat_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk_int($sformatf("repeat_pos%0d", i), got_q[i], exp_q[i]);
    btn_raw[STEP_BTN] = 1'b0;
    lat = 0;
    do begin tick(); lat++; end while (!btn_release[STEP_BTN] && lat < 30);
    chk_bit("repeat_released", btn_level[STEP_BTN], 1'b0);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (step_en) cnt++;
    end
    chk_int("repeat_after_release", cnt, 0);

    // 5: run mode, then back to single step
    sw_raw[RUN_SW] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!sw_level[RUN_SW] && n < 30);
    chk_bit("run_level_up", sw_level[RUN_SW], 1'b1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (step_en) cnt++;
    end
    chk_int("run_step_const", cnt, 10);
    sw_raw[RUN_SW] = 1'b0;
    n = 0;
    do begin tick(); n++; end while (sw_level[RUN_SW] && n < 30);
    chk_bit("run_drop_level", sw_level[RUN_SW], 1'b0);
    chk_bit("run_drop_step", step_en, 1'b0);
    btn_raw[STEP_BTN] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (step_en) cnt++;
    end
    chk_int("single_step_pulses", cnt, 1);
    btn_raw[STEP_BTN] = 1'b0;
    for (int i = 0; i < 12; i++) tick();

    // 6: reset mid-debounce and mid-repeat discards state
    btn_raw[3] = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    do_reset(2);
    lat = 0;
    do begin tick(); lat++; end while (!btn_press[3] && lat < 30);
    chk_int("relaunch_latency", lat, DB + 2);
    btn_raw[3] = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    btn_raw[STEP_BTN] = 1'b1;
    lat = 0;
    do begin tick(); lat++; end while (!btn_press[STEP_BTN] && lat < 30);
    for (int i = 0; i < 24; i++) tick();
    do_reset(2);
    lat = 0;
    do begin tick(); lat++; end while (!btn_press[STEP_BTN] && lat < 30);
    chk_int("repeat_reset_latency", lat, DB + 2);
    cnt = 0;
    for (int i = 0; i < RD - 1; i++) begin
      tick();
      if (step_en) cnt++;
    end
    chk_int("repeat_reset_no_pulse", cnt, 0);
    btn_raw = '0;
    for (int i = 0; i < 12; i++) tick();

    // Random sticky toggling on every channel
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < NUM_BTN; b++)
        if ($urandom_range(0, 5) == 0) btn_raw[b] = ~btn_raw[b];
      for (int s = 0; s < NUM_SW; s++)
        if ($urandom_range(0, 5) == 0) sw_raw[s] = ~sw_raw[s];
      tick();
    end
    btn_raw = '0;
    sw_raw  = '0;
    for (int i = 0; i < 12; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
